// File: rtl/pixel_compositor_pkg.sv
// Shared types and defaults for the pixel compositor: FSM state encoding,
// screen/sprite geometry defaults and the transparent colour key.
package pixel_compositor_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        WAIT_SPR = 3'd2,
        WAIT_BG  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPR_W       = 32;
    localparam int DEF_SPR_H       = 52;
    localparam int DEF_SHEET_COLS  = 4;
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_SHEET_BASE  = 307201;
    localparam int DEF_ADDR_W      = 20;
    localparam int CALC_W          = 22;

    localparam logic [23:0] TRANSPARENT_KEY = 24'h000000;

    function automatic logic is_transparent(input logic [23:0] rgb);
        return (rgb == TRANSPARENT_KEY);
    endfunction

endpackage

// File: rtl/pixel_compositor_sprite_addr_gen.sv
// Hit test and sprite-sheet word address for one sprite layer, including the
// optional horizontal mirror of the column offset.
module sprite_addr_gen
    import pixel_compositor_pkg::*;
#(
    parameter int SPR_W      = DEF_SPR_W,
    parameter int SPR_H      = DEF_SPR_H,
    parameter int SHEET_COLS = DEF_SHEET_COLS,
    parameter int SHEET_BASE = DEF_SHEET_BASE,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic [10:0]       draw_x,
    input  logic [10:0]       draw_y,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic              en,
    input  logic [3:0]        sel,
    input  logic              flip,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    localparam int PITCH = SHEET_COLS * SPR_W;

    logic [10:0] x_lo_s;
    logic [10:0] y_lo_s;
    logic [10:0] x_hi_s;
    logic [10:0] y_hi_s;
    logic [10:0] col_s;
    logic [10:0] row_s;
    logic [10:0] col_eff_s;

    // 11-bit bounds cannot wrap: a 10-bit origin plus a sprite dimension stays below 2048
    assign x_lo_s = {1'b0, spr_x};
    assign y_lo_s = {1'b0, spr_y};
    assign x_hi_s = x_lo_s + 11'(SPR_W);
    assign y_hi_s = y_lo_s + 11'(SPR_H);

    assign hit = en && (draw_x >= x_lo_s) && (draw_x < x_hi_s)
                    && (draw_y >= y_lo_s) && (draw_y < y_hi_s);

    assign col_s     = draw_x - x_lo_s;
    assign row_s     = draw_y - y_lo_s;
    assign col_eff_s = flip ? (11'(SPR_W - 1) - col_s) : col_s;

    assign addr = ADDR_W'(CALC_W'(SHEET_BASE)
                        + CALC_W'(PITCH) * (CALC_W'(row_s) + CALC_W'(sel[3:2]) * CALC_W'(SPR_H))
                        + CALC_W'(col_eff_s) + CALC_W'(sel[1:0]) * CALC_W'(SPR_W));

endmodule

// File: rtl/pixel_compositor.sv
// Sprite-over-background pixel compositor: scans sprite layers in priority
// order, fetches one texel at a time and falls back to the background frame.
// Optional horizontal mirroring is enabled with PIXEL_COMPOSITOR_MIRROR_EN.
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int SHEET_COLS  = DEF_SHEET_COLS,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int SHEET_BASE  = DEF_SHEET_BASE,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        pix_req,
    output logic                        pix_ready,
    input  logic [10:0]                 DrawX,
    input  logic [10:0]                 DrawY,
    input  logic [NUM_SPRITES-1:0][9:0] spr_x,
    input  logic [NUM_SPRITES-1:0][9:0] spr_y,
    input  logic [NUM_SPRITES-1:0]      spr_en,
    input  logic [NUM_SPRITES-1:0][3:0] spr_sel,
`ifdef PIXEL_COMPOSITOR_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]      spr_flip,
`endif
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rdvalid,
    output logic [7:0]                  Red,
    output logic [7:0]                  Green,
    output logic [7:0]                  Blue,
    output logic                        pix_valid
);

    localparam int K_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    state_t                      state_r, state_nxt_s;
    logic [K_W-1:0]              k_r, k_nxt_s;
    logic [10:0]                 x_r, y_r;
    logic [NUM_SPRITES-1:0][9:0] spr_x_r, spr_y_r;
    logic [NUM_SPRITES-1:0][3:0] spr_sel_r;
    logic [NUM_SPRITES-1:0]      spr_en_r;
    logic [NUM_SPRITES-1:0]      flip_r;
    logic [NUM_SPRITES-1:0]      flip_in_s;
    logic                        mem_rd_r, rd_nxt_s;
    logic [ADDR_W-1:0]           mem_addr_r, addr_nxt_s;
    logic [23:0]                 rgb_r, rgb_nxt_s;
    logic                        pix_valid_r, valid_nxt_s;
    logic                        load_s;
    logic                        hit_s;
    logic                        last_s;
    logic                        off_screen_s;
    logic [ADDR_W-1:0]           spr_addr_s;
    logic [ADDR_W-1:0]           bg_addr_s;
    logic                        unused_rdata_s;

`ifdef PIXEL_COMPOSITOR_MIRROR_EN
    assign flip_in_s = spr_flip;
`else
    assign flip_in_s = '0;
`endif

    assign unused_rdata_s = &{1'b0, mem_rdata[31:24]};

    // One address generator is shared by all layers; the current index k selects its inputs
    sprite_addr_gen #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .SHEET_COLS (SHEET_COLS),
        .SHEET_BASE (SHEET_BASE),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .draw_x (x_r),
        .draw_y (y_r),
        .spr_x  (spr_x_r[k_r]),
        .spr_y  (spr_y_r[k_r]),
        .en     (spr_en_r[k_r]),
        .sel    (spr_sel_r[k_r]),
        .flip   (flip_r[k_r]),
        .hit    (hit_s),
        .addr   (spr_addr_s)
    );

    assign last_s       = (k_r == K_W'(NUM_SPRITES - 1));
    assign off_screen_s = (x_r >= 11'(SCREEN_W)) || (y_r >= 11'(SCREEN_H));
    assign bg_addr_s    = ADDR_W'(CALC_W'(x_r) + CALC_W'(SCREEN_W) * CALC_W'(y_r));

    // Next-state, read-strobe and colour decisions
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        rd_nxt_s    = 1'b0;
        addr_nxt_s  = mem_addr_r;
        rgb_nxt_s   = rgb_r;
        valid_nxt_s = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pix_req) begin
                    load_s      = 1'b1;
                    k_nxt_s     = '0;
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (off_screen_s) begin
                    rgb_nxt_s   = 24'h000000;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = DONE;
                end else if (hit_s) begin
                    rd_nxt_s    = 1'b1;
                    addr_nxt_s  = spr_addr_s;
                    state_nxt_s = WAIT_SPR;
                end else if (last_s) begin
                    rd_nxt_s    = 1'b1;
                    addr_nxt_s  = bg_addr_s;
                    state_nxt_s = WAIT_BG;
                end else begin
                    k_nxt_s     = k_r + K_W'(1);
                end
            end
            WAIT_SPR: begin
                if (!mem_rdvalid) begin
                    state_nxt_s = WAIT_SPR;
                end else if (!is_transparent(mem_rdata[23:0])) begin
                    rgb_nxt_s   = mem_rdata[23:0];
                    valid_nxt_s = 1'b1;
                    state_nxt_s = DONE;
                end else if (last_s) begin
                    // transparent texel on the lowest layer: only the background remains
                    rd_nxt_s    = 1'b1;
                    addr_nxt_s  = bg_addr_s;
                    state_nxt_s = WAIT_BG;
                end else begin
                    k_nxt_s     = k_r + K_W'(1);
                    state_nxt_s = SCAN;
                end
            end
            WAIT_BG: begin
                if (mem_rdvalid) begin
                    rgb_nxt_s   = mem_rdata[23:0];
                    valid_nxt_s = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT_BG;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, layer index and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            k_r         <= '0;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= '0;
            rgb_r       <= 24'h000000;
            pix_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            mem_rd_r    <= rd_nxt_s;
            mem_addr_r  <= addr_nxt_s;
            rgb_r       <= rgb_nxt_s;
            pix_valid_r <= valid_nxt_s;
        end
    end

    // Request snapshot taken on acceptance
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_r       <= 11'd0;
            y_r       <= 11'd0;
            spr_x_r   <= '0;
            spr_y_r   <= '0;
            spr_sel_r <= '0;
            spr_en_r  <= '0;
            flip_r    <= '0;
        end else if (load_s) begin
            x_r       <= DrawX;
            y_r       <= DrawY;
            spr_x_r   <= spr_x;
            spr_y_r   <= spr_y;
            spr_sel_r <= spr_sel;
            spr_en_r  <= spr_en;
            flip_r    <= flip_in_s;
        end
    end

    assign pix_ready = (state_r == IDLE);
    assign mem_rd    = mem_rd_r;
    assign mem_addr  = mem_addr_r;
    assign Red       = rgb_r[23:16];
    assign Green     = rgb_r[15:8];
    assign Blue      = rgb_r[7:0];
    assign pix_valid = pix_valid_r;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor with a one-cycle memory
// responder; the mirror case runs only when PIXEL_COMPOSITOR_MIRROR_EN is set.
module tb_pixel_compositor;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             pix_req = 1'b0;
    logic             pix_ready;
    logic [10:0]      DrawX = 11'd0;
    logic [10:0]      DrawY = 11'd0;
    logic [3:0][9:0]  spr_x = '0;
    logic [3:0][9:0]  spr_y = '0;
    logic [3:0]       spr_en = 4'd0;
    logic [3:0][3:0]  spr_sel = '0;
`ifdef PIXEL_COMPOSITOR_MIRROR_EN
    logic [3:0]       spr_flip = 4'd0;
`endif
    logic             mem_rd;
    logic [19:0]      mem_addr;
    logic [31:0]      mem_rdata = 32'd0;
    logic             mem_rdvalid = 1'b0;
    logic [7:0]       Red, Green, Blue;
    logic             pix_valid;

    int               n_cmp = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               pv_count = 0;
    int               lat;
    int               pv_before;
    logic             mem_auto = 1'b1;
    logic             inject = 1'b0;
    logic [31:0]      inject_data = 32'd0;
    logic [31:0]      rd_q[$];
    logic [19:0]      addr_log[$];

    pixel_compositor dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_req     (pix_req),
        .pix_ready   (pix_ready),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .spr_sel     (spr_sel),
`ifdef PIXEL_COMPOSITOR_MIRROR_EN
        .spr_flip    (spr_flip),
`endif
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rdvalid (mem_rdvalid),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue),
        .pix_valid   (pix_valid)
    );

    always #5 Clk = ~Clk;

    // Cycle counter and pix_valid pulse counter
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (pix_valid) pv_count <= pv_count + 1;
    end

    // Memory responder: data one cycle after each strobe, plus manual stale-valid injection
    always @(posedge Clk) begin
        mem_rdvalid <= 1'b0;
        if (inject) begin
            mem_rdvalid <= 1'b1;
            mem_rdata   <= inject_data;
        end else if (mem_rd) begin
            addr_log.push_back(mem_addr);
            if (mem_auto) begin
                mem_rdvalid <= 1'b1;
                if (rd_q.size() > 0) mem_rdata <= rd_q.pop_front();
                else                 mem_rdata <= 32'd0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_sprites();
        spr_en  = 4'd0;
        spr_x   = '0;
        spr_y   = '0;
        spr_sel = '0;
`ifdef PIXEL_COMPOSITOR_MIRROR_EN
        spr_flip = 4'd0;
`endif
        addr_log.delete();
        rd_q.delete();
    endtask

    // Issue one request and wait (bounded) for pix_valid; lat = -1 on timeout
    task automatic run_pixel(input logic [10:0] x, input logic [10:0] y, input string tag);
        int acc;
        lat = -1;
        @(negedge Clk);
        for (int i = 0; i < 20 && !pix_ready; i++) @(negedge Clk);
        DrawX   = x;
        DrawY   = y;
        pix_req = 1'b1;
        @(posedge Clk);
        #1;
        acc     = cyc;
        pix_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (pix_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        @(negedge Clk);
        check({tag, "_pulse_width"}, {31'd0, pix_valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_ready", {31'd0, pix_ready}, 32'd1);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_ready_after", {31'd0, pix_ready}, 32'd1);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_addr", {12'd0, mem_addr}, 32'd0);
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);

        // background only
        clear_sprites();
        rd_q.push_back(32'h00123456);
        run_pixel(11'd10, 11'd2, "bg");
        check("bg_latency", lat, 32'd6);
        check("bg_reads", addr_log.size(), 32'd1);
        check("bg_addr", {12'd0, addr_log[0]}, 32'd1290);
        check("bg_rgb", {8'd0, Red, Green, Blue}, 32'h00123456);

        // single sprite hit, sheet cell row 1 col 1
        clear_sprites();
        spr_en = 4'b0001; spr_x[0] = 10'd100; spr_y[0] = 10'd100; spr_sel[0] = 4'b0101;
        rd_q.push_back(32'h00ABCDEF);
        run_pixel(11'd101, 11'd102, "hit");
        check("hit_latency", lat, 32'd3);
        check("hit_reads", addr_log.size(), 32'd1);
        check("hit_addr", {12'd0, addr_log[0]}, 32'd314146);
        check("hit_rgb", {8'd0, Red, Green, Blue}, 32'h00ABCDEF);

        // overlap: sprite 0 transparent, sprite 1 red
        clear_sprites();
        spr_en = 4'b0011;
        spr_x[0] = 10'd200; spr_y[0] = 10'd50; spr_sel[0] = 4'b0000;
        spr_x[1] = 10'd190; spr_y[1] = 10'd40; spr_sel[1] = 4'b0010;
        rd_q.push_back(32'h00000000);
        rd_q.push_back(32'h00FF0000);
        run_pixel(11'd205, 11'd60, "ovl");
        check("ovl_reads", addr_log.size(), 32'd2);
        check("ovl_addr0", {12'd0, addr_log[0]}, 32'd308486);
        check("ovl_addr1", {12'd0, addr_log[1]}, 32'd309840);
        check("ovl_rgb", {8'd0, Red, Green, Blue}, 32'h00FF0000);

        // bottom-right corner of the sprite is still inside
        clear_sprites();
        spr_en = 4'b0001; spr_x[0] = 10'd100; spr_y[0] = 10'd100;
        rd_q.push_back(32'h00112233);
        run_pixel(11'd131, 11'd151, "edge_in");
        check("edge_in_addr", {12'd0, addr_log[0]}, 32'd313760);
        check("edge_in_rgb", {8'd0, Red, Green, Blue}, 32'h00112233);

        // one past the right edge misses; black background is latched
        clear_sprites();
        spr_en = 4'b0001; spr_x[0] = 10'd100; spr_y[0] = 10'd100;
        rd_q.push_back(32'h00000000);
        run_pixel(11'd132, 11'd100, "edge_out");
        check("edge_out_reads", addr_log.size(), 32'd1);
        check("edge_out_addr", {12'd0, addr_log[0]}, 32'd64132);
        check("edge_out_rgb", {8'd0, Red, Green, Blue}, 32'h00000000);
        check("edge_out_latency", lat, 32'd6);

        // lowest-priority sprite transparent falls through to background
        clear_sprites();
        spr_en = 4'b1000; spr_x[3] = 10'd0; spr_y[3] = 10'd0;
        rd_q.push_back(32'h00000000);
        rd_q.push_back(32'h00445566);
        run_pixel(11'd5, 11'd5, "fall");
        check("fall_reads", addr_log.size(), 32'd2);
        check("fall_addr0", {12'd0, addr_log[0]}, 32'd307846);
        check("fall_addr1", {12'd0, addr_log[1]}, 32'd3205);
        check("fall_rgb", {8'd0, Red, Green, Blue}, 32'h00445566);

        // off-screen coordinates: no read, colour 0
        clear_sprites();
        run_pixel(11'd640, 11'd0, "offx");
        check("offx_reads", addr_log.size(), 32'd0);
        check("offx_rgb", {8'd0, Red, Green, Blue}, 32'd0);
        check("offx_done", {31'd0, lat > 0}, 32'd1);
        rd_q.push_back(32'h00998877);
        run_pixel(11'd3, 11'd1, "refill");
        check("refill_rgb", {8'd0, Red, Green, Blue}, 32'h00998877);
        clear_sprites();
        run_pixel(11'd0, 11'd480, "offy");
        check("offy_reads", addr_log.size(), 32'd0);
        check("offy_rgb", {8'd0, Red, Green, Blue}, 32'd0);

`ifdef PIXEL_COMPOSITOR_MIRROR_EN
        clear_sprites();
        spr_en = 4'b0001; spr_flip = 4'b0001;
        rd_q.push_back(32'h00777777);
        run_pixel(11'd0, 11'd0, "mirror");
        check("mirror_addr", {12'd0, addr_log[0]}, 32'd307232);
        check("mirror_rgb", {8'd0, Red, Green, Blue}, 32'h00777777);
`endif

        // leave a non-zero colour so the reset clear is visible
        clear_sprites();
        rd_q.push_back(32'h00CAFE01);
        run_pixel(11'd7, 11'd7, "pre_rst");
        check("pre_rst_rgb", {8'd0, Red, Green, Blue}, 32'h00CAFE01);

        // reset while a sprite fetch is outstanding, stale rdvalid afterwards
        clear_sprites();
        mem_auto = 1'b0;
        spr_en = 4'b0001; spr_x[0] = 10'd100; spr_y[0] = 10'd100; spr_sel[0] = 4'b0101;
        @(negedge Clk);
        DrawX = 11'd101; DrawY = 11'd102; pix_req = 1'b1;
        @(posedge Clk);
        #1;
        pix_req = 1'b0;
        for (int i = 0; i < 20 && addr_log.size() == 0; i++) @(negedge Clk);
        check("mid_reads", addr_log.size(), 32'd1);
        check("mid_ready", {31'd0, pix_ready}, 32'd0);
        pv_before = pv_count;
        Reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, pix_ready}, 32'd1);
        check("mid_rst_addr", {12'd0, mem_addr}, 32'd0);
        check("mid_rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        inject_data = 32'h00FFFFFF;
        inject = 1'b1;
        @(negedge Clk);
        inject = 1'b0;
        repeat (5) @(negedge Clk);
        check("stale_pv", pv_count - pv_before, 32'd0);
        check("stale_rgb", {8'd0, Red, Green, Blue}, 32'd0);
        check("stale_ready", {31'd0, pix_ready}, 32'd1);
        check("stale_mem_rd", {31'd0, mem_rd}, 32'd0);
        mem_auto = 1'b1;

        // normal operation resumes after reset
        clear_sprites();
        rd_q.push_back(32'h00123456);
        run_pixel(11'd10, 11'd2, "recover");
        check("recover_addr", {12'd0, addr_log[0]}, 32'd1290);
        check("recover_rgb", {8'd0, Red, Green, Blue}, 32'h00123456);
        check("recover_latency", lat, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
